cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_FU functional units completing out of order.
- Grants one requester per cycle using round-robin priority, then registers the winner's result onto the CDB.
- The CDB drives the reorder buffer's completion inputs (tag, write-back data, target PC, mispredict) and reservation-station wakeup.
- The reorder buffer's flush squashes every pending request and any in-flight broadcast.

Parameters:
- NUM_FU, 4, number of requesting functional units (>=2).
- XLEN, 32, data and PC width.
- ROB_TAG_LEN, 5, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  ROB mispredict flush, synchronous.
- fu_valid  in  NUM_FU  per-FU result-valid.
- fu_ready  out  NUM_FU  per-FU grant (combinational, one-hot or zero).
- fu_rob_tag  in  NUM_FU*ROB_TAG_LEN  per-FU ROB tag; FU i occupies slice i.
- fu_data  in  NUM_FU*XLEN  per-FU write-back data.
- fu_target_pc  in  NUM_FU*XLEN  per-FU resolved branch target.
- fu_mispredict  in  NUM_FU  per-FU mispredict flag.
- cdb_valid  out  1  registered broadcast valid (ROB cdb_to_rob).
- cdb_rob_tag  out  ROB_TAG_LEN  registered tag.
- cdb_data  out  XLEN  registered data.
- cdb_target_pc  out  XLEN  registered target PC.
- cdb_mispredict  out  1  registered mispredict.
- rr_ptr  out  $clog2(NUM_FU)  current highest-priority FU index (debug/verification).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All cdb_* outputs = 0 and rr_ptr = 0.
  - fu_ready = 0 while reset_n is low.
- Handshake: a transfer occurs when fu_valid[i] && fu_ready[i] at a rising edge.
  - An FU holds fu_valid and its payload stable until accepted.
  - fu_ready does not depend on whether the FU is already granted, only on fu_valid and priority.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_FU.
  - The first i with fu_valid[i]=1 gets fu_ready[i]=1; all others get 0.
  - No valid requester: fu_ready = 0.
- Pointer update: on a transfer from FU k, rr_ptr <= (k+1) mod NUM_FU. With k=NUM_FU-1 it wraps to 0. No transfer: rr_ptr holds.
- Latency: a payload accepted at edge t appears on cdb_* immediately after edge t, for exactly one cycle.
  - Back-to-back grants give one broadcast per cycle; throughput is 1/cycle.
  - Next cycle without a transfer: cdb_valid <= 0. The cdb_* payload holds its last value, which is don't-care when cdb_valid=0.
- Flush (flush=1 in a cycle):
  - fu_ready = 0 combinationally, so no transfer occurs.
  - cdb_valid <= 0 and rr_ptr <= 0.
  - FUs are responsible for dropping their own requests; the arbiter keeps no request queue.
- Fairness: a continuously requesting FU waits at most NUM_FU-1 grants to other FUs before its own grant.
- Single requester: granted every cycle it is valid; rr_ptr repeatedly moves to k+1.
- Simultaneous flush and reset: reset dominates.
- Reset deasserted mid-stream: the first grant occurs on the first edge with reset_n=1, with priority starting from FU 0.
- No other state: no buffering beyond the output register; no starvation counters.

Test Plan:
- Reset: reset_n=0 with all fu_valid=1 -> fu_ready=0000, cdb_valid=0, rr_ptr=0. After release, first edge grants FU0; cdb_rob_tag=fu_rob_tag[0] next cycle.
- Round robin: fu_valid=1111 held for 8 cycles, tags 3/7/11/15 -> grant order 0,1,2,3,0,1,2,3; CDB tags 3,7,11,15,3,... one cycle later; rr_ptr 1,2,3,0 (wrap).
- Skip and wrap: rr_ptr=3, fu_valid=0101 -> FU0 granted, rr_ptr=1. Next cycle same requests -> FU2 granted, rr_ptr=3.
- Payload: FU2 data=32'hDEADBEEF, target_pc=32'h0000_0400, mispredict=1, tag=9 -> next cycle cdb_valid=1 with identical fields. Following idle cycle -> cdb_valid=0.
- Flush: flush=1 with fu_valid=1111 and rr_ptr=2 -> fu_ready=0000, next cycle cdb_valid=0 and rr_ptr=0. Flush falls with fu_valid=0010 -> FU1 granted.
- Async reset mid-stream: reset_n pulled low between edges while cdb_valid=1 -> cdb_valid drops to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the common data bus among NUM_FU
// out-of-order functional units. The winning FU's result is registered onto
// the CDB for exactly one cycle. A ROB flush blocks grants, drops any pending
// broadcast and returns priority to FU 0.
module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*ROB_TAG_LEN-1:0] fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]        fu_data,
  input  logic [NUM_FU*XLEN-1:0]        fu_target_pc,
  input  logic [NUM_FU-1:0]             fu_mispredict,
  output logic                          cdb_valid,
  output logic [ROB_TAG_LEN-1:0]        cdb_rob_tag,
  output logic [XLEN-1:0]               cdb_data,
  output logic [XLEN-1:0]               cdb_target_pc,
  output logic                          cdb_mispredict,
  output logic [$clog2(NUM_FU)-1:0]     rr_ptr
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W:0]   inc_sum;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  // Grants are suppressed during reset and flush.
  always_comb begin
    fu_ready  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (reset_n && !flush) begin
      for (int unsigned off = 0; off < NUM_FU; off++) begin
        // Wrap explicitly so non-power-of-two NUM_FU still scans correctly.
        scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
        if (scan_sum >= (PTR_W+1)'(NUM_FU))
          scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
        scan_idx = scan_sum[PTR_W-1:0];
        if (!grant_any && fu_valid[scan_idx]) begin
          grant_any          = 1'b1;
          grant_idx          = scan_idx;
          fu_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  // Priority moves to the FU just after the winner, wrapping to 0.
  always_comb begin
    inc_sum = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (inc_sum >= (PTR_W+1)'(NUM_FU))
      next_ptr = '0;
    else
      next_ptr = inc_sum[PTR_W-1:0];
  end

  // Output register and priority pointer; payload holds when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid      <= 1'b0;
      cdb_rob_tag    <= '0;
      cdb_data       <= '0;
      cdb_target_pc  <= '0;
      cdb_mispredict <= 1'b0;
      rr_ptr         <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (grant_any) begin
      cdb_valid      <= 1'b1;
      cdb_rob_tag    <= fu_rob_tag[grant_idx*ROB_TAG_LEN +: ROB_TAG_LEN];
      cdb_data       <= fu_data[grant_idx*XLEN +: XLEN];
      cdb_target_pc  <= fu_target_pc[grant_idx*XLEN +: XLEN];
      cdb_mispredict <= fu_mispredict[grant_idx];
      rr_ptr         <= next_ptr;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed, table-driven bench for cdb_arbiter (NUM_FU=4).
module tb_cdb_arbiter;

  localparam int NUM_FU = 4;
  localparam int XLEN   = 32;
  localparam int TAGW   = 5;

  logic                     clk;
  logic                     reset_n;
  logic                     flush;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*TAGW-1:0]   fu_rob_tag;
  logic [NUM_FU*XLEN-1:0]   fu_data;
  logic [NUM_FU*XLEN-1:0]   fu_target_pc;
  logic [NUM_FU-1:0]        fu_mispredict;
  logic                     cdb_valid;
  logic [TAGW-1:0]          cdb_rob_tag;
  logic [XLEN-1:0]          cdb_data;
  logic [XLEN-1:0]          cdb_target_pc;
  logic                     cdb_mispredict;
  logic [1:0]               rr_ptr;

  int n_cmp;
  int n_bad;

  cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_LEN(TAGW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_rob_tag    (fu_rob_tag),
    .fu_data       (fu_data),
    .fu_target_pc  (fu_target_pc),
    .fu_mispredict (fu_mispredict),
    .cdb_valid     (cdb_valid),
    .cdb_rob_tag   (cdb_rob_tag),
    .cdb_data      (cdb_data),
    .cdb_target_pc (cdb_target_pc),
    .cdb_mispredict(cdb_mispredict),
    .rr_ptr        (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic       exp_cv;
    logic [1:0] exp_idx;
    logic [1:0] exp_rr;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Default per-FU payload: tag 4*i+3, data/pc encode the FU index.
  task automatic set_default_payload();
    for (int i = 0; i < NUM_FU; i++) begin
      fu_rob_tag[i*TAGW +: TAGW]   = TAGW'(4*i + 3);
      fu_data[i*XLEN +: XLEN]      = 32'h1000_0000 | 32'(i);
      fu_target_pc[i*XLEN +: XLEN] = 32'h2000_0000 | 32'(i);
      fu_mispredict[i]             = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    fu_valid = 4'b1111;
    set_default_payload();

    vecs[0]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd1};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 2'd3};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 2'd0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd1};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 2'd3};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 2'd0};
    vecs[8]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 2'd3};
    vecs[9]  = '{1'b0, 4'b0101, 4'b0001, 1'b1, 2'd0, 2'd1};
    vecs[10] = '{1'b0, 4'b0101, 4'b0100, 1'b1, 2'd2, 2'd3};
    vecs[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd3};
    vecs[12] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[13] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 2'd0};
    vecs[14] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[15] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 2'd0};
    vecs[16] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 2'd0};

    // Reset with all requesters active.
    #1;
    chk("reset_ready", 64'(fu_ready), 64'h0);
    chk("reset_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("reset_rr_ptr", 64'(rr_ptr), 64'h0);
    chk("reset_cdb_tag", 64'(cdb_rob_tag), 64'h0);
    chk("reset_cdb_data", 64'(cdb_data), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors: each applied at a negedge, checked before and after the edge.
    for (int v = 0; v < 17; v++) begin
      flush    = vecs[v].flush;
      fu_valid = vecs[v].valid;
      #1;
      chk($sformatf("v%0d_ready", v), 64'(fu_ready), 64'(vecs[v].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cdb_valid", v), 64'(cdb_valid), 64'(vecs[v].exp_cv));
      chk($sformatf("v%0d_rr_ptr", v), 64'(rr_ptr), 64'(vecs[v].exp_rr));
      if (vecs[v].exp_cv) begin
        chk($sformatf("v%0d_cdb_tag", v), 64'(cdb_rob_tag), 64'(4*int'(vecs[v].exp_idx) + 3));
        chk($sformatf("v%0d_cdb_data", v), 64'(cdb_data), 64'(32'h1000_0000 | 32'(vecs[v].exp_idx)));
        chk($sformatf("v%0d_cdb_pc", v), 64'(cdb_target_pc), 64'(32'h2000_0000 | 32'(vecs[v].exp_idx)));
      end
      @(negedge clk);
    end
    flush = 1'b0;

    // Full payload transfer from FU2, then an idle cycle.
    fu_rob_tag[2*TAGW +: TAGW]   = 5'd9;
    fu_data[2*XLEN +: XLEN]      = 32'hDEAD_BEEF;
    fu_target_pc[2*XLEN +: XLEN] = 32'h0000_0400;
    fu_mispredict[2]             = 1'b1;
    fu_valid = 4'b0100;
    #1;
    chk("pay_ready", 64'(fu_ready), 64'h4);
    @(posedge clk);
    #1;
    chk("pay_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("pay_cdb_tag", 64'(cdb_rob_tag), 64'd9);
    chk("pay_cdb_data", 64'(cdb_data), 64'hDEAD_BEEF);
    chk("pay_cdb_pc", 64'(cdb_target_pc), 64'h0000_0400);
    chk("pay_cdb_mispredict", 64'(cdb_mispredict), 64'h1);
    chk("pay_rr_ptr", 64'(rr_ptr), 64'd3);
    @(negedge clk);
    fu_valid = 4'b0000;
    set_default_payload();
    @(posedge clk);
    #1;
    chk("idle_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("idle_rr_ptr", 64'(rr_ptr), 64'd3);
    @(negedge clk);

    // Asynchronous reset between edges while a broadcast is live.
    fu_valid = 4'b1111;
    @(posedge clk);
    #1;
    chk("async_pre_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("async_pre_cdb_tag", 64'(cdb_rob_tag), 64'd15);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("async_rr_ptr", 64'(rr_ptr), 64'h0);
    chk("async_ready", 64'(fu_ready), 64'h0);
    // Flush together with reset: reset still holds everything clear.
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_flush_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_flush_rr_ptr", 64'(rr_ptr), 64'h0);
    @(negedge clk);
    flush   = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("release_ready", 64'(fu_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("release_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("release_cdb_tag", 64'(cdb_rob_tag), 64'd3);
    chk("release_rr_ptr", 64'(rr_ptr), 64'd1);
    @(negedge clk);
    fu_valid = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
